// File: rtl/obc_challenge_issuer.sv
// OBC watchdog challenge issuer: emits LFSR questions, waits for the answer
// or a timeout, and hands one {question, answer, timeout} record downstream.
module obc_challenge_issuer #(
  parameter int          PERIOD_CYCLES  = 5000,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [3:0]  LFSR_SEED      = 4'b1001,
  parameter int          CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       q_valid,
  output logic [3:0] q_data,
  input  logic       a_valid,
  input  logic [3:0] a_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_question,
  output logic [3:0] res_answer,
  output logic       res_timeout,
  output logic [7:0] challenge_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PERIOD,
    S_ISSUE,
    S_WAIT_ANS,
    S_DELIVER
  } state_t;

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [3:0] SEED =
    (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] PER_LAST =
    CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       lfsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_valid_q;
  logic [3:0]       q_data_q;
  logic             res_valid_q;
  logic [3:0]       res_question_q;
  logic [3:0]       res_answer_q;
  logic             res_timeout_q;
  logic [7:0]       count_q;
  logic [3:0]       lfsr_d;

  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED;
      cnt_q          <= '0;
      q_valid_q      <= 1'b0;
      q_data_q       <= 4'b0000;
      res_valid_q    <= 1'b0;
      res_question_q <= 4'b0000;
      res_answer_q   <= 4'b0000;
      res_timeout_q  <= 1'b0;
      count_q        <= 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_WAIT_PERIOD;
            cnt_q   <= '0;
          end
        end
        S_WAIT_PERIOD: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (cnt_q == PER_LAST) begin
            state_q <= S_ISSUE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ISSUE: begin
          q_data_q  <= lfsr_q;
          q_valid_q <= 1'b1;
          lfsr_q    <= lfsr_d;
          cnt_q     <= '0;
          state_q   <= S_WAIT_ANS;
        end
        S_WAIT_ANS: begin
          // An answer in the last timeout cycle still counts.
          if (a_valid || (cnt_q == TO_LAST)) begin
            res_answer_q   <= a_valid ? a_data : 4'b0000;
            res_timeout_q  <= !a_valid;
            q_valid_q      <= 1'b0;
            res_question_q <= q_data_q;
            res_valid_q    <= 1'b1;
            state_q        <= S_DELIVER;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DELIVER: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
            if (count_q != 8'hFF) begin
              count_q <= count_q + 8'd1;
            end
            state_q <= enable ? S_WAIT_PERIOD : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign q_valid         = q_valid_q;
  assign q_data          = q_data_q;
  assign res_valid       = res_valid_q;
  assign res_question    = res_question_q;
  assign res_answer      = res_answer_q;
  assign res_timeout     = res_timeout_q;
  assign challenge_count = count_q;

endmodule

// File: tb/tb_obc_challenge_issuer.sv
// Bench for obc_challenge_issuer: table of challenge scenarios with
// hand-computed records, plus reset and enable-drop sequences.
module tb_obc_challenge_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       q_valid;
  logic [3:0] q_data;
  logic       a_valid;
  logic [3:0] a_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_question;
  logic [3:0] res_answer;
  logic       res_timeout;
  logic [7:0] challenge_count;

  int nvec = 0;
  int nerr = 0;

  obc_challenge_issuer #(
    .PERIOD_CYCLES (4),
    .TIMEOUT_CYCLES(8),
    .LFSR_SEED     (4'b1001),
    .CNT_W         (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .q_valid        (q_valid),
    .q_data         (q_data),
    .a_valid        (a_valid),
    .a_data         (a_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_question   (res_question),
    .res_answer     (res_answer),
    .res_timeout    (res_timeout),
    .challenge_count(challenge_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         issue_lat;
    int         ans_dly;
    logic [3:0] a_dat;
    int         stall;
    bit         drop_en;
    logic [3:0] exp_q;
    logic [3:0] exp_a;
    logic       exp_to;
    int         exp_lat;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {q_valid, q_data, res_valid, res_question,
            res_answer, res_timeout, challenge_count};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit bad;
    logic [9:0] snap;
    enable = 1'b1;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (q_valid) break;
    end
    chk($sformatf("v%0d issue_lat", idx), n, v.issue_lat);
    chk($sformatf("v%0d q_data", idx), q_data, v.exp_q);
    n = 0;
    while (n < 30) begin
      if (n == v.ans_dly) begin
        a_valid = 1'b1;
        a_data  = v.a_dat;
      end
      step();
      n++;
      a_valid = 1'b0;
      a_data  = 4'b0000;
      if (res_valid) break;
    end
    chk($sformatf("v%0d res_lat", idx), n, v.exp_lat);
    chk($sformatf("v%0d q_valid_drop", idx), q_valid, 1'b0);
    chk($sformatf("v%0d record", idx),
        {res_question, res_answer, res_timeout},
        {v.exp_q, v.exp_a, v.exp_to});
    snap = {res_valid, res_question, res_answer, res_timeout};
    bad = 1'b0;
    for (int i = 0; i < v.stall; i++) begin
      if (v.drop_en) enable = 1'b0;
      a_valid = 1'b1;
      a_data  = 4'b1111;
      step();
      if ({res_valid, res_question, res_answer, res_timeout} != snap
          || q_valid)
        bad = 1'b1;
    end
    a_valid = 1'b0;
    a_data  = 4'b0000;
    if (v.stall > 0)
      chk($sformatf("v%0d stall_stable", idx), bad, 1'b0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk($sformatf("v%0d accept", idx),
        {res_valid, challenge_count}, {1'b0, v.exp_cnt});
    if (v.drop_en) begin
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (q_valid) bad = 1'b1;
      end
      chk($sformatf("v%0d idle_after_drop", idx), bad, 1'b0);
    end
  endtask

  initial begin
    int n;
    //        lat dly dat    stl drp q       a       to  rl cnt
    tbl[0] = '{6, 1, 4'b0110, 0, 0, 4'b1001, 4'b0110, 0, 2, 8'd1};
    tbl[1] = '{5, 0, 4'b1111, 0, 0, 4'b0011, 4'b1111, 0, 1, 8'd2};
    tbl[2] = '{5, -1, 4'b0111, 0, 0, 4'b0110, 4'b0000, 1, 8, 8'd3};
    tbl[3] = '{5, 7, 4'b1010, 0, 0, 4'b1101, 4'b1010, 0, 8, 8'd4};
    tbl[4] = '{5, 3, 4'b0101, 10, 0, 4'b1010, 4'b0101, 0, 4, 8'd5};
    tbl[5] = '{5, 2, 4'b0011, 10, 1, 4'b0101, 4'b0011, 0, 3, 8'd6};
    tbl[6] = '{6, 1, 4'b0110, 0, 0, 4'b1001, 4'b0110, 0, 2, 8'd1};

    reset     = 1'b1;
    enable    = 1'b0;
    a_valid   = 1'b0;
    a_data    = 4'b0000;
    res_ready = 1'b0;
    #1;
    chk("reset_outs", outs(), 23'd0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Re-enable, issue, then reset in the middle of WAIT_ANS.
    enable = 1'b1;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (q_valid) break;
    end
    chk("reen issue_lat", n, 6);
    chk("reen q_data", q_data, 4'b1011);
    step();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outs", outs(), 23'd0);
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
    run_vec(tbl[6], 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
